// File: rtl/cod_pkg.sv
// Shared widths, FSM encoding and stream payload for the RAM drain stage.
package cod_pkg;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } word_t;
endpackage

// File: rtl/fifo2_skid.sv
// Two-entry register FIFO; entry 0 is the head and drives the stream directly.
module fifo2_skid
  import cod_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  word_t      push_data_i,
  input  logic       pop_i,
  output word_t      head_o,
  output logic       valid_o,
  output logic       full_o,
  output logic [1:0] cnt_o
);
  word_t      e0_q, e0_d, e1_q, e1_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] slot_c;
  logic       valid_q, full_q;
  logic       pop_c, push_c;

  assign pop_c  = pop_i && (cnt_q != 2'd0);
  assign push_c = push_i && ((cnt_q != 2'd2) || pop_c);
  assign slot_c = cnt_q - 2'(pop_c);

  // Pop shifts entry 1 forward; a push lands in the first slot left free.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (pop_c) e0_d = e1_q;
    if (push_c) begin
      if (slot_c == 2'd0) e0_d = push_data_i;
      else                e1_d = push_data_i;
    end
    cnt_d = cnt_q + 2'(push_c) - 2'(pop_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q    <= '0;
      e1_q    <= '0;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      cnt_q   <= cnt_d;
      valid_q <= (cnt_d != 2'd0);
      full_q  <= (cnt_d == 2'd2);
    end
  end

  assign head_o  = e0_q;
  assign valid_o = valid_q;
  assign full_o  = full_q;
  assign cnt_o   = cnt_q;
endmodule

// File: rtl/ram_stream_reader.sv
// Drains a contiguous RAM window onto a valid/ready stream with credit-based read issue.
module ram_stream_reader
  import cod_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, issued_q, issued_d, capt_q, capt_d;
  logic              pending_q, pending_d, busy_q, busy_d, done_q, done_d;
  logic              pop_c, issue_c, last_pop_c;
  logic [2:0]        credit_c;
  logic [1:0]        fifo_cnt;
  logic              fifo_valid, fifo_full;
  word_t             head, push_word;

  assign pop_c      = fifo_valid && out_ready;
  assign last_pop_c = pop_c && head.last;
  // Slots already spoken for once this cycle's pop is taken into account.
  assign credit_c   = 3'(fifo_cnt) + 3'(pending_q) - 3'(pop_c);
  assign issue_c    = (state_q == ST_RUN) && (issued_q < cnt_q) && (credit_c < 3'd2);

  assign push_word.last = (capt_q == cnt_q - CNT_W'(1));
  assign push_word.data = ram_dout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start && (count != CNT_W'(0))) state_d = ST_RUN;
      ST_RUN:  if (last_pop_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    issued_d  = issued_q;
    capt_d    = capt_q;
    pending_d = issue_c;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          cnt_d    = count;
          issued_d = '0;
          capt_d   = '0;
          if (count == CNT_W'(0)) done_d = 1'b1;
          else                    busy_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (issue_c) begin
          addr_d   = addr_q + ADDR_W'(1);
          issued_d = issued_q + CNT_W'(1);
        end
        if (pending_q) capt_d = capt_q + CNT_W'(1);
        if (last_pop_c) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      cnt_q     <= '0;
      issued_q  <= '0;
      capt_q    <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      issued_q  <= issued_d;
      capt_q    <= capt_d;
      pending_q <= pending_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  fifo2_skid u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (pending_q),
    .push_data_i (push_word),
    .pop_i       (pop_c),
    .head_o      (head),
    .valid_o     (fifo_valid),
    .full_o      (fifo_full),
    .cnt_o       (fifo_cnt)
  );

  assign ram_addr  = addr_q;
  assign out_valid = fifo_valid;
  assign out_data  = head.data;
  assign out_last  = head.last;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Downstream drain stage for the datapath RAM's read port B (6-bit address, 32-bit data, synchronous read, one-cycle latency).
- After the ALU/regfile sequence has written results into RAM, a start pulse makes this block read a contiguous address window.
- Each word is presented on a valid/ready stream, full throughput, with correct handling of backpressure.
- The consumer is a display/UART serializer or a testbench scoreboard.

Parameters:
ADDR_W, 6, RAM address width
DATA_W, 32, RAM data width
CNT_W, ADDR_W+1, width of word count (range 0..2^ADDR_W)

Ports:
clk  in  1  system clock, all logic rising-edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a dump when idle
base_addr  in  ADDR_W  first RAM address, latched on accepted start
count  in  CNT_W  number of words, latched on accepted start
ram_addr  out  ADDR_W  to RAM addrb; driven directly from a register
ram_dout  in  DATA_W  from RAM doutb; valid the cycle after ram_addr is sampled
out_valid  out  1  stream word valid
out_data  out  DATA_W  stream word
out_last  out  1  marks final word of the dump; qualified by out_valid
out_ready  in  1  consumer accepts when out_valid and out_ready are both high
busy  out  1  high from accepted start until the final handshake
done  out  1  one-cycle pulse after completion

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: ram_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0. FSM goes to IDLE, FIFO empty, pending=0, all counters 0.
- FSM states:
  - IDLE: start=1 latches base_addr/count and goes to RUN; busy=1 next cycle.
  - IDLE with start=1 and count==0: stays IDLE; done=1 the next cycle; no stream output.
  - RUN: a read is issued when issued<count and (fifo_cnt + pending - pop) < 2, where pop = out_valid & out_ready.
  - RUN exit: when the word with out_last is popped, go to DONE.
  - DONE: one cycle; done=1, busy=0; then IDLE.
- start is ignored while busy or in DONE.
- Issue mechanics:
  - ram_addr holds the current read address.
  - On issue, ram_addr <= ram_addr+1 (mod 2^ADDR_W, wrap-around allowed), issued++, pending <= 1.
  - When no read is issued, pending <= 0.
- Capture: when pending=1, ram_dout is written into a 2-entry FIFO in the same cycle.
  - The word tagged last has capture index == count-1 (separate capture counter).
- Output: out_valid/out_data/out_last come from the FIFO head, registered in the FIFO storage.
  - Push and pop in the same cycle are both allowed; with the FIFO full, a pop frees one slot.
  - The credit rule guarantees no overflow. Overflow is an assertion failure in the bench.
- Latency: with out_ready held high, the first word is valid 2 cycles after the start edge. The first read is issued in the first RUN cycle, so ram_addr=base in that cycle. After that, one word per cycle.
- Backpressure: the FIFO holds at most 2 words and at most 1 read is in flight. ram_addr stalls while credit is exhausted.
- out_data is stable while out_valid=1 and out_ready=0.
- Reset asserted mid-dump clears everything immediately. No partial done pulse. The RAM contents are untouched.
- ram_addr is not restored to 0 after a dump; it holds the last value until the next start.

Decomposition:
- Shared package cod_pkg holds ADDR_W/DATA_W defaults and the FSM state encoding (IDLE, RUN, DONE).
- One sub-module, fifo2_skid: 2-entry register FIFO with push/pop/full/empty/count and simultaneous push+pop. Each entry stores data plus the last bit.
- Top module: FSM, issue/capture counters, credit logic.

Test Plan:
- Preload RAM[0..3]=1,1,2,3; start base=0 count=4 with out_ready=1 -> out_data 1,1,2,3 on 4 consecutive cycles; out_last on the 4th; done pulse 1 cycle later; busy low with done.
- Wrap: base=62 count=4 -> ram_addr sequence 62,63,0,1 with matching data; out_last on the RAM[1] word.
- Backpressure: count=8, out_ready pseudo-random (50%) -> all 8 words in order, no drop or duplicate; out_data stable while stalled; no FIFO overflow assertion.
- count=0 -> no out_valid; done=1 exactly one cycle after start; busy stays 0.
- start pulsed again mid-dump (count=6) -> ignored; exactly 6 words and one done.
- rst_n low during the 3rd word of count=8 -> outputs go to reset values at once. A following start base=0 count=2 outputs RAM[0],RAM[1] correctly.
